// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory-access stage: FSM state encoding,
// WriteSrc encodings, the default load-response timeout and the
// writeback data selector.
package mem_access_pkg;

    // Memory-stage controller states
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_WAIT = 2'b10,
        ST_DONE = 2'b11
    } mau_state_e;

    // WriteSrc encodings
    localparam logic [1:0] WSRC_ALU = 2'b00;
    localparam logic [1:0] WSRC_MEM = 2'b01;
    localparam logic [1:0] WSRC_PC4 = 2'b10;
    localparam logic [1:0] WSRC_IMM = 2'b11;

    // Cycles to wait for a load response before aborting
    localparam int RESP_TIMEOUT_DEFAULT = 255;

    // Writeback data selector
    function automatic logic [31:0] wb_select(
        input logic [1:0]  src,
        input logic [31:0] alu,
        input logic [31:0] mem,
        input logic [31:0] pc4,
        input logic [31:0] imm
    );
        logic [31:0] res;
        case (src)
            WSRC_ALU: res = alu;
            WSRC_MEM: res = mem;
            WSRC_PC4: res = pc4;
            default:  res = imm;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mau_timeout_ctr.sv
// Load-response timeout counter. Cleared while 'clear' is high, counts
// while 'enable' is high, and flags 'expire' when it reaches LIMIT-1.
module mau_timeout_ctr #(
    parameter int LIMIT = 255
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int            CW   = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0] count_reg;

    // Count cycles spent waiting; saturate at the terminal value
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable && (count_reg != LAST)) begin
            count_reg <= count_reg + ONE;
        end
    end

    assign expire = enable && (count_reg == LAST);

endmodule

// File: rtl/mem_access_unit.sv
// MEM pipeline stage: drives the data-memory request handshake for loads
// and stores, stalls upstream while a bus access is in flight and
// registers the MEM/WB writeback bundle.
// Optional build macro: MAU_MISALIGN_CHECK_EN -- when defined, accesses
// with a non word-aligned address are dropped without a bus request and
// flagged on misalign_o.
module mem_access_unit #(
    parameter int RESP_TIMEOUT = mem_access_pkg::RESP_TIMEOUT_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    // EX/MEM register
    input  logic [31:0] ALUout_i,
    input  logic        RegWrite_i,
    input  logic [1:0]  WriteSrc_i,
    input  logic        MemWrite_i,
    input  logic [31:0] ImmOp_i,
    input  logic [31:0] pcPlus4_i,
    input  logic [31:0] regOp2_i,
    input  logic [4:0]  rd_i,
    // Data memory bus
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_gnt_i,
    input  logic        dmem_rvalid_i,
    input  logic [31:0] dmem_rdata_i,
    // Pipeline control
    output logic        stall_o,
    // MEM/WB writeback bundle
    output logic        RegWrite_o,
    output logic [4:0]  rd_o,
    output logic [31:0] WriteData_o,
    // Error pulses
    output logic        bus_err_o,
    output logic        misalign_o
);

    import mem_access_pkg::*;

    mau_state_e  state_reg, state_next;

    logic        is_store, is_load, is_access, misaligned;
    logic        launch, capture, timeout, mis_hit, wb_load, suppress;
    logic        tmo_expire;

    logic [31:0] addr_reg, wdata_reg, rdata_reg;
    logic        we_reg, bus_err_reg, misalign_reg;

    // A load that is also a store is handled as a store
    assign is_store  = MemWrite_i;
    assign is_load   = (WriteSrc_i == WSRC_MEM) && !MemWrite_i;
    assign is_access = is_store || is_load;

`ifdef MAU_MISALIGN_CHECK_EN
    assign misaligned = is_access && (ALUout_i[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    // Timeout counter restarts every time WAIT is entered
    mau_timeout_ctr #(
        .LIMIT (RESP_TIMEOUT)
    ) u_timeout_ctr (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clear  (state_reg != ST_WAIT),
        .enable (state_reg == ST_WAIT),
        .expire (tmo_expire)
    );

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state decode plus handshake/stall outputs and datapath strobes
    always_comb begin
        state_next = state_reg;
        stall_o    = 1'b0;
        dmem_req_o = 1'b0;
        launch     = 1'b0;
        capture    = 1'b0;
        timeout    = 1'b0;
        mis_hit    = 1'b0;
        wb_load    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (is_access) begin
                    stall_o = 1'b1;
                    if (misaligned) begin
                        mis_hit    = 1'b1;
                        state_next = ST_DONE;
                    end else begin
                        launch     = 1'b1;
                        state_next = ST_REQ;
                    end
                end else begin
                    wb_load = 1'b1;
                end
            end
            ST_REQ: begin
                stall_o    = 1'b1;
                dmem_req_o = 1'b1;
                if (dmem_gnt_i) begin
                    if (we_reg) begin
                        state_next = ST_DONE;
                    end else if (dmem_rvalid_i) begin
                        capture    = 1'b1;
                        state_next = ST_DONE;
                    end else begin
                        state_next = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                stall_o = 1'b1;
                if (dmem_rvalid_i) begin
                    capture    = 1'b1;
                    state_next = ST_DONE;
                end else if (tmo_expire) begin
                    timeout    = 1'b1;
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                wb_load    = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Latch the bus request when leaving IDLE so it stays stable until granted
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_reg  <= '0;
            wdata_reg <= '0;
            we_reg    <= 1'b0;
        end else if (launch) begin
            addr_reg  <= ALUout_i;
            wdata_reg <= regOp2_i;
            we_reg    <= is_store;
        end
    end

    assign dmem_addr_o  = addr_reg;
    assign dmem_wdata_o = wdata_reg;
    assign dmem_we_o    = we_reg;

    // Capture load data; aborted accesses leave zero behind
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_reg <= '0;
        end else if (capture) begin
            rdata_reg <= dmem_rdata_i;
        end else if (timeout || mis_hit) begin
            rdata_reg <= '0;
        end
    end

    // Error flags are high exactly for the DONE cycle of a failed access
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bus_err_reg  <= 1'b0;
            misalign_reg <= 1'b0;
        end else begin
            bus_err_reg  <= timeout;
            misalign_reg <= mis_hit;
        end
    end

    assign bus_err_o = bus_err_reg;
`ifdef MAU_MISALIGN_CHECK_EN
    assign misalign_o = misalign_reg;
`else
    assign misalign_o = 1'b0;
`endif

    // A failed access must not write the register file
    assign suppress = bus_err_reg || misalign_reg;

    // MEM/WB bundle: load on pass-through or completion, bubble while stalled
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            RegWrite_o  <= 1'b0;
            rd_o        <= '0;
            WriteData_o <= '0;
        end else if (wb_load) begin
            RegWrite_o  <= RegWrite_i && !suppress;
            rd_o        <= rd_i;
            WriteData_o <= wb_select(WriteSrc_i, ALUout_i, rdata_reg, pcPlus4_i, ImmOp_i);
        end else begin
            RegWrite_o  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit (RESP_TIMEOUT = 4).
// Table-driven pass-through vectors followed by hand-written multi-cycle
// sequences for store, load, timeout, reset abort and alignment handling.
module tb_mem_access_unit;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [31:0] ALUout_i;
    logic        RegWrite_i;
    logic [1:0]  WriteSrc_i;
    logic        MemWrite_i;
    logic [31:0] ImmOp_i;
    logic [31:0] pcPlus4_i;
    logic [31:0] regOp2_i;
    logic [4:0]  rd_i;
    logic        dmem_req_o, dmem_we_o;
    logic [31:0] dmem_addr_o, dmem_wdata_o;
    logic        dmem_gnt_i, dmem_rvalid_i;
    logic [31:0] dmem_rdata_i;
    logic        stall_o, RegWrite_o;
    logic [4:0]  rd_o;
    logic [31:0] WriteData_o;
    logic        bus_err_o, misalign_o;

    int assert_cnt = 0;
    int fail_cnt   = 0;

    mem_access_unit #(
        .RESP_TIMEOUT (4)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .ALUout_i      (ALUout_i),
        .RegWrite_i    (RegWrite_i),
        .WriteSrc_i    (WriteSrc_i),
        .MemWrite_i    (MemWrite_i),
        .ImmOp_i       (ImmOp_i),
        .pcPlus4_i     (pcPlus4_i),
        .regOp2_i      (regOp2_i),
        .rd_i          (rd_i),
        .dmem_req_o    (dmem_req_o),
        .dmem_we_o     (dmem_we_o),
        .dmem_addr_o   (dmem_addr_o),
        .dmem_wdata_o  (dmem_wdata_o),
        .dmem_gnt_i    (dmem_gnt_i),
        .dmem_rvalid_i (dmem_rvalid_i),
        .dmem_rdata_i  (dmem_rdata_i),
        .stall_o       (stall_o),
        .RegWrite_o    (RegWrite_o),
        .rd_o          (rd_o),
        .WriteData_o   (WriteData_o),
        .bus_err_o     (bus_err_o),
        .misalign_o    (misalign_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        reg_write;
        logic [1:0]  wsrc;
        logic [31:0] alu;
        logic [31:0] imm;
        logic [31:0] pc4;
        logic [4:0]  rd;
        logic [31:0] exp_wd;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        assert_cnt++;
        if (act !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_nop();
        ALUout_i   = '0;
        RegWrite_i = 1'b0;
        WriteSrc_i = 2'b00;
        MemWrite_i = 1'b0;
        ImmOp_i    = '0;
        pcPlus4_i  = '0;
        regOp2_i   = '0;
        rd_i       = '0;
    endtask

    task automatic set_load(input logic [31:0] addr, input logic [4:0] rd);
        set_nop();
        WriteSrc_i = 2'b01;
        ALUout_i   = addr;
        rd_i       = rd;
        RegWrite_i = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int req_cnt;
        int wait_cnt;

        // pass-through vectors: WriteData source selection
        vecs[0] = '{1'b1, 2'b10, 32'h0000_0011, 32'h0000_0022, 32'h0000_0104, 5'd5,  32'h0000_0104};
        vecs[1] = '{1'b1, 2'b00, 32'hCAFE_0000, 32'h0000_0001, 32'h0000_0008, 5'd10, 32'hCAFE_0000};
        vecs[2] = '{1'b1, 2'b11, 32'h0000_0003, 32'hFFFF_F800, 32'h0000_0010, 5'd31, 32'hFFFF_F800};
        vecs[3] = '{1'b0, 2'b00, 32'h0000_0055, 32'h0000_0000, 32'h0000_0000, 5'd0,  32'h0000_0055};
        vecs[4] = '{1'b1, 2'b10, 32'h0000_0000, 32'h0000_0000, 32'h0000_0020, 5'd1,  32'h0000_0020};

        // reset state
        rst_ni        = 1'b0;
        dmem_gnt_i    = 1'b0;
        dmem_rvalid_i = 1'b0;
        dmem_rdata_i  = '0;
        set_nop();
        #2;
        check("rst_regwrite", 32'(RegWrite_o), 32'd0);
        check("rst_rd",       32'(rd_o),       32'd0);
        check("rst_wdata",    WriteData_o,     32'd0);
        check("rst_req",      32'(dmem_req_o), 32'd0);
        check("rst_buserr",   32'(bus_err_o),  32'd0);
        check("rst_misalign", 32'(misalign_o), 32'd0);
        check("rst_stall",    32'(stall_o),    32'd0);
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        tick();

        // table-driven pass-through, latency 1, never stalls
        for (int i = 0; i < 5; i++) begin
            set_nop();
            RegWrite_i = vecs[i].reg_write;
            WriteSrc_i = vecs[i].wsrc;
            ALUout_i   = vecs[i].alu;
            ImmOp_i    = vecs[i].imm;
            pcPlus4_i  = vecs[i].pc4;
            rd_i       = vecs[i].rd;
            #1;
            check($sformatf("vec%0d_stall", i), 32'(stall_o), 32'd0);
            tick();
            check($sformatf("vec%0d_regwrite", i), 32'(RegWrite_o), 32'(vecs[i].reg_write));
            check($sformatf("vec%0d_rd", i),       32'(rd_o),       32'(vecs[i].rd));
            check($sformatf("vec%0d_wdata", i),    WriteData_o,     vecs[i].exp_wd);
            $display("vec %0d: wsrc=%0b rd=%0d wdata=0x%08h", i, vecs[i].wsrc, rd_o, WriteData_o);
        end

        // store, grant on the third REQ cycle
        set_nop();
        MemWrite_i = 1'b1;
        ALUout_i   = 32'h0000_0080;
        regOp2_i   = 32'hDEAD_BEEF;
        rd_i       = 5'd3;
        #1;
        check("st_idle_stall", 32'(stall_o), 32'd1);
        tick();
        req_cnt = 0;
        for (int c = 0; c < 3; c++) begin
            dmem_gnt_i = (c == 2);
            #1;
            if (dmem_req_o) req_cnt++;
            check($sformatf("st_addr_c%0d", c),  dmem_addr_o,       32'h0000_0080);
            check($sformatf("st_wdata_c%0d", c), dmem_wdata_o,      32'hDEAD_BEEF);
            check($sformatf("st_we_c%0d", c),    32'(dmem_we_o),    32'd1);
            check($sformatf("st_stall_c%0d", c), 32'(stall_o),      32'd1);
            check($sformatf("st_rw_c%0d", c),    32'(RegWrite_o),   32'd0);
            tick();
        end
        dmem_gnt_i = 1'b0;
        #1;
        check("st_req_cycles", 32'(req_cnt),    32'd3);
        check("st_done_req",   32'(dmem_req_o), 32'd0);
        check("st_done_stall", 32'(stall_o),    32'd0);
        tick();
        set_nop();
        #1;
        check("st_wb_regwrite", 32'(RegWrite_o), 32'd0);
        $display("store: addr=0x80 req_cycles=%0d regwrite=%0b", req_cnt, RegWrite_o);

        // load, immediate grant, data two cycles later
        set_load(32'h0000_0040, 5'd7);
        #1;
        check("ld_idle_stall", 32'(stall_o), 32'd1);
        tick();
        dmem_gnt_i = 1'b1;
        #1;
        check("ld_req",  32'(dmem_req_o), 32'd1);
        check("ld_we",   32'(dmem_we_o),  32'd0);
        check("ld_addr", dmem_addr_o,     32'h0000_0040);
        tick();
        dmem_gnt_i = 1'b0;
        #1;
        check("ld_wait_req",   32'(dmem_req_o), 32'd0);
        check("ld_wait_stall", 32'(stall_o),    32'd1);
        check("ld_wait_rw",    32'(RegWrite_o), 32'd0);
        tick();
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 32'h1234_5678;
        #1;
        check("ld_wait2_stall", 32'(stall_o), 32'd1);
        tick();
        dmem_rvalid_i = 1'b0;
        dmem_rdata_i  = '0;
        #1;
        check("ld_done_stall", 32'(stall_o),    32'd0);
        check("ld_done_rw",    32'(RegWrite_o), 32'd0);
        tick();
        set_nop();
        #1;
        check("ld_wb_rw",    32'(RegWrite_o), 32'd1);
        check("ld_wb_rd",    32'(rd_o),       32'd7);
        check("ld_wb_wdata", WriteData_o,     32'h1234_5678);
        $display("load: addr=0x40 rd=%0d wdata=0x%08h", rd_o, WriteData_o);
        tick();
        check("ld_wb_once", 32'(RegWrite_o), 32'd0);

        // load timeout: no response
        set_load(32'h0000_0044, 5'd9);
        tick();
        dmem_gnt_i = 1'b1;
        tick();
        dmem_gnt_i = 1'b0;
        wait_cnt = 0;
        for (int c = 0; c < 20 && !bus_err_o; c++) begin
            #1;
            if (stall_o && !dmem_req_o) wait_cnt++;
            if (!bus_err_o) tick();
        end
        check("tmo_wait_cycles", 32'(wait_cnt),   32'd4);
        check("tmo_buserr",      32'(bus_err_o),  32'd1);
        check("tmo_done_stall",  32'(stall_o),    32'd0);
        tick();
        set_nop();
        #1;
        check("tmo_buserr_pulse", 32'(bus_err_o),  32'd0);
        check("tmo_rw",           32'(RegWrite_o), 32'd0);
        check("tmo_wdata",        WriteData_o,     32'd0);
        check("tmo_idle_stall",   32'(stall_o),    32'd0);
        $display("timeout: wait_cycles=%0d regwrite=%0b", wait_cnt, RegWrite_o);

        // load with grant and data in the same cycle
        set_load(32'h0000_0048, 5'd2);
        tick();
        dmem_gnt_i    = 1'b1;
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 32'hA5A5_0001;
        tick();
        dmem_gnt_i    = 1'b0;
        dmem_rvalid_i = 1'b0;
        dmem_rdata_i  = '0;
        #1;
        check("fast_done_stall", 32'(stall_o), 32'd0);
        tick();
        set_nop();
        #1;
        check("fast_rw",    32'(RegWrite_o), 32'd1);
        check("fast_rd",    32'(rd_o),       32'd2);
        check("fast_wdata", WriteData_o,     32'hA5A5_0001);
        $display("fast load: rd=%0d wdata=0x%08h", rd_o, WriteData_o);

        // spurious gnt/rvalid while idle are ignored
        dmem_gnt_i    = 1'b1;
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 32'hFFFF_FFFF;
        #1;
        check("spur_req",   32'(dmem_req_o), 32'd0);
        check("spur_stall", 32'(stall_o),    32'd0);
        tick();
        check("spur_rw",    32'(RegWrite_o), 32'd0);
        check("spur_wdata", WriteData_o,     32'd0);
        dmem_gnt_i    = 1'b0;
        dmem_rvalid_i = 1'b0;
        dmem_rdata_i  = '0;
        $display("spurious handshake in idle: req=%0b", dmem_req_o);

        // reset during WAIT abandons the load
        set_nop();
        RegWrite_i = 1'b1;
        ALUout_i   = 32'h0000_0077;
        rd_i       = 5'd12;
        tick();
        set_load(32'h0000_0050, 5'd6);
        tick();
        dmem_gnt_i = 1'b1;
        tick();
        dmem_gnt_i = 1'b0;
        #1;
        check("rstw_pre_rd", 32'(rd_o), 32'd12);
        rst_ni        = 1'b0;
        set_nop();
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 32'hBAD0_BAD0;
        #1;
        check("rstw_rd",     32'(rd_o),       32'd0);
        check("rstw_wdata",  WriteData_o,     32'd0);
        check("rstw_rw",     32'(RegWrite_o), 32'd0);
        check("rstw_req",    32'(dmem_req_o), 32'd0);
        check("rstw_buserr", 32'(bus_err_o),  32'd0);
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            check($sformatf("rstw_post_stall%0d", c), 32'(stall_o),    32'd0);
            check($sformatf("rstw_post_req%0d", c),   32'(dmem_req_o), 32'd0);
            check($sformatf("rstw_post_rw%0d", c),    32'(RegWrite_o), 32'd0);
            check($sformatf("rstw_post_wd%0d", c),    WriteData_o,     32'd0);
        end
        dmem_rvalid_i = 1'b0;
        dmem_rdata_i  = '0;
        $display("reset in wait: rvalid ignored, wdata=0x%08h", WriteData_o);

        // misaligned load at 0x42
        set_load(32'h0000_0042, 5'd4);
        #1;
        check("mis_idle_stall", 32'(stall_o),    32'd1);
        check("mis_idle_req",   32'(dmem_req_o), 32'd0);
`ifdef MAU_MISALIGN_CHECK_EN
        tick();
        check("mis_done_req",   32'(dmem_req_o), 32'd0);
        check("mis_pulse",      32'(misalign_o), 32'd1);
        check("mis_done_stall", 32'(stall_o),    32'd0);
        tick();
        set_nop();
        #1;
        check("mis_pulse_end", 32'(misalign_o), 32'd0);
        check("mis_rw",        32'(RegWrite_o), 32'd0);
        $display("misaligned load 0x42: dropped, regwrite=%0b", RegWrite_o);
`else
        tick();
        dmem_gnt_i    = 1'b1;
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 32'h0BAD_F00D;
        #1;
        check("unal_req",      32'(dmem_req_o), 32'd1);
        check("unal_addr",     dmem_addr_o,     32'h0000_0042);
        check("unal_misalign", 32'(misalign_o), 32'd0);
        tick();
        dmem_gnt_i    = 1'b0;
        dmem_rvalid_i = 1'b0;
        dmem_rdata_i  = '0;
        #1;
        check("unal_done_misalign", 32'(misalign_o), 32'd0);
        tick();
        set_nop();
        #1;
        check("unal_rw",    32'(RegWrite_o), 32'd1);
        check("unal_wdata", WriteData_o,     32'h0BAD_F00D);
        $display("unaligned load 0x42: passed through, wdata=0x%08h", WriteData_o);
`endif

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter RESP_TIMEOUT, default 255: max cycles waiting for load response before abort.
REQ-002 clk_i  in  1  single clock, all state updates on posedge.
REQ-003 rst_ni  in  1  asynchronous, active-low reset.
REQ-004 ALUout_i  in  32  effective address / ALU result from EX/MEM register.
REQ-005 RegWrite_i  in  1; WriteSrc_i  in  2; MemWrite_i  in  1; ImmOp_i  in  32; pcPlus4_i  in  32; regOp2_i  in  32 (store data); rd_i  in  5.
REQ-006 dmem_req_o  out  1; dmem_we_o  out  1; dmem_addr_o  out  32; dmem_wdata_o  out  32.
REQ-007 dmem_gnt_i  in  1  request accepted; dmem_rvalid_i  in  1  load data valid; dmem_rdata_i  in  32.
REQ-008 stall_o  out  1  hold EX/MEM register and upstream stages.
REQ-009 RegWrite_o  out  1; rd_o  out  5; WriteData_o  out  32: registered MEM/WB writeback bundle.
REQ-010 bus_err_o  out  1  one-cycle pulse on load timeout; misalign_o  out  1  one-cycle pulse on misaligned access.

Function
REQ-011 Load = WriteSrc_i==2'b01; store = MemWrite_i==1; access = load or store; load and store together SHALL be treated as store.
REQ-012 WriteData select: 00 ALUout_i, 01 load data, 10 pcPlus4_i, 11 ImmOp_i.
REQ-013 FSM states IDLE, REQ, WAIT, DONE.
REQ-014 IDLE, no access: stall_o=0; bundle registered at next edge (latency 1), next IDLE.
REQ-015 IDLE, access: stall_o=1, RegWrite_o=0 at next edge, next REQ.
REQ-016 REQ: dmem_req_o=1; addr=ALUout_i, wdata=regOp2_i, we=store, all held stable until dmem_gnt_i.
REQ-017 REQ+gnt: store -> DONE; load -> WAIT; load with gnt and rvalid same cycle -> DONE, capturing rdata.
REQ-018 WAIT: dmem_req_o=0; on rvalid capture dmem_rdata_i -> DONE; counter increments each cycle, reset on WAIT entry.
REQ-019 WAIT, counter==RESP_TIMEOUT-1 without rvalid: -> DONE, load data forced 0, RegWrite suppressed, bus_err_o pulses in DONE.
REQ-020 DONE: stall_o=0; bundle registered at next edge with captured data; next IDLE; instruction consumed exactly once.
REQ-021 stall_o=1 in REQ and WAIT; while stalled RegWrite_o=0 each edge (bubble).
REQ-022 rvalid outside WAIT/REQ SHALL be ignored; gnt outside REQ SHALL be ignored.

Reset
REQ-023 rst_ni low: state IDLE, counter 0, RegWrite_o=0, rd_o=0, WriteData_o=0, dmem_req_o=0, bus_err_o=0, misalign_o=0, captured data 0.
REQ-024 Reset mid-transaction SHALL abandon it immediately; no pending response is consumed after release.
REQ-025 stall_o is combinational from state and inputs; only IDLE-with-access drives 1 after reset.

Configuration
REQ-026 Macro MAU_MISALIGN_CHECK_EN defined: access with ALUout_i[1:0]!=0 in IDLE -> DONE without bus request, RegWrite suppressed, misalign_o pulses in DONE.
REQ-027 Macro undefined: no check, misalign_o tied 0, address passed unmodified.

Structure
REQ-028 Package mem_access_pkg holds state enum, WriteSrc encoding constants, RESP_TIMEOUT default.
REQ-029 Sub-module mau_timeout_ctr: clear/enable/expire counter sized from RESP_TIMEOUT.

Verification
REQ-030 WriteSrc=10, pcPlus4=0x104, RegWrite=1, rd=5 -> next edge RegWrite_o=1, rd_o=5, WriteData_o=0x104, stall_o never 1.
REQ-031 Store addr 0x80, data 0xDEADBEEF, gnt after 3 REQ cycles -> req held 3 cycles, addr/wdata/we stable, DONE 1 cycle, RegWrite_o=0.
REQ-032 Load addr 0x40, gnt immediate, rvalid 2 cycles later with 0x12345678, rd=7 -> WriteData_o=0x12345678, rd_o=7, RegWrite_o=1 once.
REQ-033 Load, gnt, no rvalid, RESP_TIMEOUT=4 -> bus_err_o one pulse after 4 WAIT cycles, RegWrite_o=0, back to IDLE.
REQ-034 rst_ni low during WAIT, then rvalid -> all outputs reset, rvalid ignored, IDLE.
REQ-035 MAU_MISALIGN_CHECK_EN, load addr 0x42 -> no dmem_req_o, misalign_o one pulse, RegWrite_o=0.
